// File: rtl/multiply_add_pkg.sv
// Shared definitions for the radix-4 online multiply-add datapath.
//   digit_t       3-bit two's complement signed digit in {-2..2}
//   DIG_*         the five legal digit encodings
//   digit_legal   true for a legal digit encoding
//   ma_state_t    controller states
package multiply_add_pkg;

  typedef logic [2:0] digit_t;

  localparam digit_t DIG_0  = 3'b000;
  localparam digit_t DIG_P1 = 3'b001;
  localparam digit_t DIG_P2 = 3'b010;
  localparam digit_t DIG_M1 = 3'b111;
  localparam digit_t DIG_M2 = 3'b110;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} ma_state_t;

  // Encodings 011, 100 and 101 fall outside {-2..2}.
  function automatic logic digit_legal(digit_t d);
    return (d == DIG_0) || (d == DIG_P1) || (d == DIG_P2) ||
           (d == DIG_M1) || (d == DIG_M2);
  endfunction

endpackage

// File: rtl/multiply_add_stage.sv
// One purely combinational iteration of the radix-4 online multiply-add.
// Residual value w = ws + wc, fixed point with FRAC fractional bits, where
// FRAC = (M-1) + 2*DELTA so that a*x*4^-DELTA and c*4^-DELTA are exact.
//   v      = 4*w + (a*x + c) * 4^-DELTA
//   y      = round(v) clamped to {-2..2}, forced to 0 while j < DELTA
//   w_next = v - y
// Ports:
//   a_i               signed fraction operand (a / 2^(M-1))
//   ws_i, wc_i        carry-save residual in
//   x_i, c_i          input digits (already legalised by the controller)
//   j_i               iteration index
//   y_o               output digit
//   wsNext_o/wcNext_o carry-save residual out
module multiply_add_stage
  import multiply_add_pkg::*;
#(
  parameter int M               = 8,
  parameter int RESIDUAL_WIDTH  = 19,
  parameter int TRUNCATED_WIDTH = 19,
  parameter int J               = 4,
  parameter int DELTA           = 2
) (
  input  logic [M-1:0]              a_i,
  input  logic [RESIDUAL_WIDTH-1:0] ws_i,
  input  logic [RESIDUAL_WIDTH-1:0] wc_i,
  input  digit_t                    x_i,
  input  digit_t                    c_i,
  input  logic [J-1:0]              j_i,
  output digit_t                    y_o,
  output logic [RESIDUAL_WIDTH-1:0] wsNext_o,
  output logic [RESIDUAL_WIDTH-1:0] wcNext_o
);

  localparam int RW       = RESIDUAL_WIDTH;
  localparam int TW       = TRUNCATED_WIDTH;
  localparam int FRAC     = (M - 1) + 2 * DELTA;
  localparam int DROP     = RW - TW;
  localparam int EST_FRAC = FRAC - DROP;

  localparam logic signed [TW-1:0] HALF = TW'(1) << (EST_FRAC - 1);
  localparam logic signed [TW-1:0] TWO  = TW'(2);
  localparam logic signed [TW-1:0] MTWO = -TW'(2);

  logic signed [RW-1:0] aExt, xExt, cExt, term;
  logic signed [RW-1:0] ws4, wc4, sum1, carry1;
  logic signed [RW-1:0] yExt, negY;
  logic signed [TW-1:0] est, rounded;
  logic signed [2:0]    yVal;

  // The term a*x + c*2^(M-1) lands directly in FRAC units; wraparound of the
  // individual carry-save words is harmless because only their modular sum
  // matters and the true residual fits the register.
  assign aExt = {{(RW-M){a_i[M-1]}}, a_i};
  assign xExt = {{(RW-3){x_i[2]}}, x_i};
  assign cExt = {{(RW-3){c_i[2]}}, c_i};
  assign term = (aExt * xExt) + (cExt <<< (M - 1));

  assign ws4    = {ws_i[RW-3:0], 2'b00};
  assign wc4    = {wc_i[RW-3:0], 2'b00};
  assign sum1   = ws4 ^ wc4 ^ term;
  assign carry1 = ((ws4 & wc4) | (ws4 & term) | (wc4 & term)) <<< 1;

  // Digit selection works on the top TW bits of each carry-save word; the
  // estimate is rounded to nearest so the next residual stays within +-1/2.
  assign est     = sum1[RW-1:DROP] + carry1[RW-1:DROP];
  assign rounded = (est + HALF) >>> EST_FRAC;

  // The first DELTA iterations only accumulate input, so no digit is emitted.
  always_comb begin
    yVal = 3'sd0;
    if (j_i < J'(DELTA)) begin
      yVal = 3'sd0;
    end else if (rounded > TWO) begin
      yVal = 3'sd2;
    end else if (rounded < MTWO) begin
      yVal = -3'sd2;
    end else begin
      yVal = rounded[2:0];
    end
  end

  assign y_o  = digit_t'(yVal);
  assign yExt = {{(RW-3){yVal[2]}}, yVal};
  assign negY = '0 - (yExt <<< FRAC);

  // Subtract the selected digit with a second 3:2 compression.
  assign wsNext_o = sum1 ^ carry1 ^ negY;
  assign wcNext_o = ((sum1 & carry1) | (sum1 & negY) | (carry1 & negY)) <<< 1;

endmodule

// File: rtl/multiply_add_controller.sv
// Digit-serial sequencer for one radix-4 online multiply-add stage.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, a               begin an operation / operand latched on start
//   in_valid, in_ready     x/c digit-pair input handshake
//   x_digit, c_digit       input digits
//   out_valid, out_ready   result digit output handshake
//   out_digit, out_last    result digit and last-digit marker
//   busy, done, err        status: active, completion pulse, sticky bad digit
module multiply_add_controller
  import multiply_add_pkg::*;
#(
  parameter int M               = 8,
  parameter int RESIDUAL_WIDTH  = 19,
  parameter int TRUNCATED_WIDTH = 19,
  parameter int J               = 4,
  parameter int N_DIGITS        = 8,
  parameter int DELTA           = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic         in_valid,
  output logic         in_ready,
  input  digit_t       x_digit,
  input  digit_t       c_digit,
  output logic         out_valid,
  input  logic         out_ready,
  output digit_t       out_digit,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int RW    = RESIDUAL_WIDTH;
  localparam int TOTAL = N_DIGITS + DELTA;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int MAXJ  = 2 ** J - 1;

  localparam logic [CW-1:0] LAST_RUN  = CW'(N_DIGITS - 1);
  localparam logic [CW-1:0] LAST_FIRE = CW'(TOTAL - 1);
  localparam logic [CW-1:0] FIRST_OUT = CW'(DELTA);

  ma_state_t     state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic [RW-1:0] ws_q, ws_d, wc_q, wc_d;
  logic [M-1:0]  a_q, a_d;
  digit_t        outDigit_q, outDigit_d;
  logic          outValid_q, outValid_d;
  logic          outLast_q, outLast_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          slotFree, runFire, flushFire, fire, producing, handshake;
  logic          xLegal, cLegal, illegalSeen;
  digit_t        stageX, stageC, stageY;
  logic [J-1:0]  jIdx;
  logic [RW-1:0] stageWsNext, stageWcNext;

  // A fire may happen whenever the output register is empty or is being
  // drained this cycle, which gives back-to-back digits with no bubble.
  assign slotFree    = !outValid_q || out_ready;
  assign runFire     = (state_q == RUN) && in_valid && slotFree;
  assign flushFire   = (state_q == FLUSH) && slotFree;
  assign fire        = runFire || flushFire;
  assign producing   = fire && (iter_q >= FIRST_OUT);
  assign handshake   = outValid_q && out_ready;

  assign xLegal      = digit_legal(x_digit);
  assign cLegal      = digit_legal(c_digit);
  assign illegalSeen = runFire && !(xLegal && cLegal);

  // Flush iterations and illegal encodings feed zero digits to the stage.
  assign stageX = ((state_q == RUN) && xLegal) ? x_digit : DIG_0;
  assign stageC = ((state_q == RUN) && cLegal) ? c_digit : DIG_0;

  // The stage index saturates at its widest representable value.
  always_comb begin
    if (int'(iter_q) > MAXJ) begin
      jIdx = J'(MAXJ);
    end else begin
      jIdx = J'(iter_q);
    end
  end

  multiply_add_stage #(
    .M               (M),
    .RESIDUAL_WIDTH  (RESIDUAL_WIDTH),
    .TRUNCATED_WIDTH (TRUNCATED_WIDTH),
    .J               (J),
    .DELTA           (DELTA)
  ) u_stage (
    .a_i      (a_q),
    .ws_i     (ws_q),
    .wc_i     (wc_q),
    .x_i      (stageX),
    .c_i      (stageC),
    .j_i      (jIdx),
    .y_o      (stageY),
    .wsNext_o (stageWsNext),
    .wcNext_o (stageWcNext)
  );

  // Next-state logic. DRAIN lasts until the cycle in which done is high, so
  // busy stays up through the done pulse and IDLE follows right after it.
  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    ws_d       = ws_q;
    wc_d       = wc_q;
    a_d        = a_q;
    outDigit_d = outDigit_q;
    outValid_d = outValid_q;
    outLast_d  = outLast_q;
    done_d     = 1'b0;
    err_d      = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          ws_d    = '0;
          wc_d    = '0;
          iter_d  = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (fire && (iter_q == LAST_RUN)) state_d = FLUSH;
      end
      FLUSH: begin
        if (fire && (iter_q == LAST_FIRE)) state_d = DRAIN;
      end
      DRAIN: begin
        if (done_q) begin
          state_d = IDLE;
        end else if (handshake) begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fire) begin
      ws_d   = stageWsNext;
      wc_d   = stageWcNext;
      iter_d = iter_q + 1'b1;
    end

    if (illegalSeen) err_d = 1'b1;

    // A producing fire overwrites the slot; otherwise a handshake empties it.
    if (producing) begin
      outDigit_d = stageY;
      outValid_d = 1'b1;
      outLast_d  = (iter_q == LAST_FIRE);
    end else if (handshake) begin
      outValid_d = 1'b0;
      outLast_d  = 1'b0;
    end
  end

  // State registers with synchronous reset; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      iter_q     <= '0;
      ws_q       <= '0;
      wc_q       <= '0;
      a_q        <= '0;
      outDigit_q <= DIG_0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      ws_q       <= ws_d;
      wc_q       <= wc_d;
      a_q        <= a_d;
      outDigit_q <= outDigit_d;
      outValid_q <= outValid_d;
      outLast_q  <= outLast_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready  = (state_q == RUN) && slotFree;
  assign out_valid = outValid_q;
  assign out_digit = outDigit_q;
  assign out_last  = outLast_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_multiply_add_controller.sv
// Testbench for multiply_add_controller. Each operation's digit string is
// compared against the exact value a*X + C computed with integer arithmetic.
module tb_multiply_add_controller;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a;
  logic [2:0] x_digit, c_digit, out_digit;
  logic       out_last, busy, done, err;

  always #5 clk = ~clk;

  multiply_add_controller dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_digit   (x_digit),
    .c_digit   (c_digit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_digit (out_digit),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int checks = 0;
  int failures = 0;

  // Operation under test and what the bench observed while running it.
  logic [7:0] aOp;
  logic [2:0] xs[8];
  logic [2:0] cs[8];
  logic [2:0] ys[$];
  logic [2:0] refQ[$];
  int lastCount, lastPos, doneCount, doneCycle, firstValidCycle;
  int busyFallCycle, errFirstCycle, errAtCycle1;
  bit errDropped;

  // Single comparison point: counts and reports a mismatch.
  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Digit value by encoding; illegal encodings count as zero.
  function automatic int digitVal(logic [2:0] d);
    case (d)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b111:  return -1;
      3'b110:  return -2;
      default: return 0;
    endcase
  endfunction

  // Runs one operation from start until busy drops, cycle 0 being the start cycle.
  task automatic applyStimulus(input bit randomFlow, input int stallFrom, input int stallLen,
                               input int midStartCycle, input logic [7:0] midStartA);
    int cyc;
    int inIdx;
    bit stalled;
    logic [2:0] heldDigit;
    ys.delete();
    lastCount = 0; lastPos = -1; doneCount = 0; doneCycle = -1;
    firstValidCycle = -1; busyFallCycle = -1; errFirstCycle = -1;
    errAtCycle1 = -1; errDropped = 0; heldDigit = 3'b000;
    @(negedge clk);
    a = aOp; start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    inIdx = 0; cyc = 0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      start    = (cyc == midStartCycle);
      a        = (cyc == midStartCycle) ? midStartA : aOp;
      in_valid = (inIdx < 8) && (!randomFlow || $urandom_range(0, 3) != 0);
      x_digit  = (inIdx < 8) ? xs[inIdx] : 3'b000;
      c_digit  = (inIdx < 8) ? cs[inIdx] : 3'b000;
      stalled  = (cyc >= stallFrom) && (cyc < stallFrom + stallLen);
      out_ready = !stalled && (!randomFlow || $urandom_range(0, 3) != 0);
      #1;
      if (stalled && cyc > stallFrom) begin
        checkOutput("stallValid", out_valid, 1);
        checkOutput("stallDigit", out_digit, heldDigit);
        checkOutput("stallInReady", in_ready, 0);
      end
      heldDigit = out_digit;
      if (cyc == 1) errAtCycle1 = err;
      if (err && errFirstCycle < 0) errFirstCycle = cyc;
      if (!err && errFirstCycle >= 0) errDropped = 1;
      if (out_valid && firstValidCycle < 0) firstValidCycle = cyc;
      if (in_valid && in_ready) inIdx++;
      if (out_valid && out_ready) begin
        ys.push_back(out_digit);
        if (out_last) begin
          lastCount++;
          lastPos = ys.size();
        end
      end
      if (done) begin
        doneCount++;
        doneCycle = cyc;
      end
      if (!busy) begin
        busyFallCycle = cyc;
        break;
      end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = aOp;
    if (busyFallCycle < 0) checkOutput("timeout", 0, 1);
  endtask

  // Compares the collected digit string with the exact value a*X + C.
  // Everything is scaled by 128*4^8, so the tolerance 4^-8 becomes 128.
  task automatic checkResult(input string name, input bit expErr);
    longint xi, ci, zs, ysum, diff;
    xi = 0; ci = 0; ysum = 0;
    for (int i = 0; i < 8; i++) begin
      xi = xi * 4 + digitVal(xs[i]);
      ci = ci * 4 + digitVal(cs[i]);
    end
    for (int i = 0; i < 8; i++) begin
      ysum = ysum * 4 + ((i < ys.size()) ? digitVal(ys[i]) : 0);
    end
    zs   = longint'($signed(aOp)) * xi + 128 * ci;
    ysum = ysum * 128;
    diff = (zs > ysum) ? zs - ysum : ysum - zs;
    checkOutput({name, " count"}, ys.size(), 8);
    checkOutput($sformatf("%s value a=%0d Z=%0d Y=%0d", name, $signed(aOp), zs, ysum),
                (diff <= 128) ? 1 : 0, 1);
    checkOutput({name, " lastCount"}, lastCount, 1);
    checkOutput({name, " lastPos"}, lastPos, 8);
    checkOutput({name, " doneCount"}, doneCount, 1);
    checkOutput({name, " errSet"}, (errFirstCycle >= 0) ? 1 : 0, expErr ? 1 : 0);
    checkOutput({name, " errSticky"}, errDropped, 0);
    checkOutput({name, " errClearedByStart"}, errAtCycle1, 0);
  endtask

  task automatic checkNoStallTiming(input string name);
    checkOutput({name, " firstValid"}, firstValidCycle, 4);
    checkOutput({name, " doneCycle"}, doneCycle, 12);
    checkOutput({name, " busyFall"}, busyFallCycle, 13);
  endtask

  task automatic compareToRef(input string name);
    int diffs;
    diffs = 0;
    for (int i = 0; i < 8; i++) begin
      if (i >= ys.size() || i >= refQ.size() || ys[i] !== refQ[i]) diffs++;
    end
    checkOutput({name, " stringDiffs"}, diffs, 0);
  endtask

  task automatic clearOperands();
    for (int i = 0; i < 8; i++) begin
      xs[i] = 3'b000;
      cs[i] = 3'b000;
    end
  endtask

  // Random legal operands kept small enough that the residual cannot overflow:
  // the value of the first three digit pairs must stay within +-1/2.
  task automatic genRandom();
    int x3, c3, z3;
    for (int tries = 0; tries < 100; tries++) begin
      aOp = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        xs[i] = 3'($urandom_range(0, 4) - 2);
        cs[i] = 3'($urandom_range(0, 4) - 2);
      end
      x3 = digitVal(xs[0]) * 16 + digitVal(xs[1]) * 4 + digitVal(xs[2]);
      c3 = digitVal(cs[0]) * 16 + digitVal(cs[1]) * 4 + digitVal(cs[2]);
      z3 = int'($signed(aOp)) * x3 + 128 * c3;
      if (z3 <= 4096 && z3 >= -4096) return;
    end
    clearOperands();
  endtask

  int nonZero;
  bit doneSeen;

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'h00; in_valid = 1'b0;
    x_digit = 3'b000; c_digit = 3'b000; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset in_ready", in_ready, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_last", out_last, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset out_digit", out_digit, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] all-zero operation");
    aOp = 8'h40;
    clearOperands();
    applyStimulus(0, 1000, 0, -1, 8'h00);
    checkResult("zero", 0);
    checkNoStallTiming("zero");
    nonZero = 0;
    foreach (ys[i]) if (ys[i] != 3'b000) nonZero++;
    checkOutput("zero nonZeroDigits", nonZero, 0);

    $display("[TB] value 0.5 * 0.25");
    clearOperands();
    xs[0] = 3'b001;
    applyStimulus(0, 1000, 0, -1, 8'h00);
    checkResult("value", 0);
    checkNoStallTiming("value");
    refQ = ys;

    $display("[TB] backpressure");
    applyStimulus(0, 6, 5, -1, 8'h00);
    checkResult("stall", 0);
    compareToRef("stall");

    $display("[TB] illegal digit");
    xs[2] = 3'b011;
    applyStimulus(0, 1000, 0, -1, 8'h00);
    checkResult("illegal", 1);
    checkOutput("illegal errFirst", errFirstCycle, 4);
    compareToRef("illegal");

    $display("[TB] start while busy");
    xs[2] = 3'b000;
    applyStimulus(0, 1000, 0, 3, 8'h7f);
    checkResult("busyStart", 0);
    compareToRef("busyStart");

    $display("[TB] random operands with random flow control");
    for (int n = 0; n < 8; n++) begin
      genRandom();
      applyStimulus(1, 1000, 0, -1, 8'h00);
      checkResult($sformatf("rand%0d", n), 0);
    end

    $display("[TB] reset mid-operation");
    aOp = 8'h40;
    @(negedge clk);
    a = aOp; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; x_digit = 3'b001; c_digit = 3'b111;
      if (k == 5) rst = 1'b1;
    end
    @(posedge clk);
    #1;
    checkOutput("midReset busy", busy, 0);
    checkOutput("midReset in_ready", in_ready, 0);
    checkOutput("midReset out_valid", out_valid, 0);
    checkOutput("midReset out_last", out_last, 0);
    checkOutput("midReset out_digit", out_digit, 0);
    checkOutput("midReset done", done, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; x_digit = 3'b000; c_digit = 3'b000;
    doneSeen = 0;
    repeat (4) begin
      @(negedge clk);
      doneSeen = doneSeen | done;
    end
    checkOutput("midReset noDone", doneSeen, 0);
    clearOperands();
    applyStimulus(0, 1000, 0, -1, 8'h00);
    checkResult("afterReset", 0);
    checkNoStallTiming("afterReset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiply_add_controller.md
# multiply_add_controller

Digit-serial sequencer for one radix-4 online multiply-add stage. Latches the parallel operand `a`, accepts a stream of signed radix-4 digit pairs (x, c) over a valid/ready handshake, and holds the carry-save residual registers between iterations. It drives the iteration index, appends online-delay flush iterations, and presents the result digits y on a backpressured output stream. It sits between the digit-stream producer and consumer and owns the only state in the multiply-add datapath.

## Interface
- `M`, 8, width of operand `a`
- `RESIDUAL_WIDTH`, 19, width of the ws/wc residual registers
- `TRUNCATED_WIDTH`, 19, truncated estimate width passed to the stage
- `J`, 4, width of the stage iteration index
- `N_DIGITS`, 8, input digits per operation; also output digits per operation
- `DELTA`, 2, online delay in iterations
- `clk`  in  1  clock; one clock; all state changes on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  begin an operation; sampled only in IDLE
- `a`  in  M  operand; latched on an accepted start
- `in_valid`  in  1  x/c digit pair valid
- `in_ready`  out  1  controller accepts the digit pair this cycle
- `x_digit`  in  3  multiplier digit, 3-bit two's complement in {-2..2}
- `c_digit`  in  3  addend digit, same encoding
- `out_valid`  out  1  `out_digit` valid
- `out_ready`  in  1  consumer accepts `out_digit`
- `out_digit`  out  3  result digit y, same encoding
- `out_last`  out  1  marks the N_DIGITS-th output digit
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse after the last output handshake
- `err`  out  1  sticky illegal-digit flag; cleared by an accepted start

## Operation
- States:
  - IDLE: start=1 latches `a`, clears ws/wc/iteration count/err, goes to RUN.
  - RUN: consumes one digit pair per fire. After N_DIGITS fires, goes to FLUSH.
  - FLUSH: performs DELTA fires with x=c=000. After the last fire, goes to DRAIN.
  - DRAIN: waits for the final output handshake, pulses `done`, goes to IDLE.
- slot_free = !out_valid || out_ready.
- RUN fire = in_valid && in_ready. `in_ready` = (state==RUN) && slot_free.
- FLUSH fire = slot_free.
- On a fire: ws/wc registers load the stage's ws_next/wc_next. The iteration count increments.
- Stage index j = min(iter, 2^J-1). The count register width is clog2(N_DIGITS+DELTA+1).
- Output production:
  - A fire with iter >= DELTA loads `out_digit` with the stage y and sets `out_valid`.
  - A fire with iter < DELTA produces no output; the stage's y is 000 for those iterations.
- `out_valid` clears on a handshake with no simultaneous producing fire. A handshake and a producing fire in the same cycle replace the digit with no bubble.
- Total fires = N_DIGITS+DELTA. Total output digits = N_DIGITS. `out_last` is high on the last one.
- Illegal encodings 011/100/101 on an accepted digit are fed to the stage as 000 and set `err`.
- Arithmetic: the output digit string satisfies sum y_i·4^-i = a·X + C to within 4^-N_DIGITS.
  - `a` is a signed fraction.
  - X and C are the input digit strings.
  - Range must not overflow the residual; that is the producer's responsibility.
- `start` outside IDLE is ignored. `in_valid` outside RUN is ignored.

## Timing
- Reset values: state IDLE; `in_ready`, `out_valid`, `out_last`, `busy`, `done`, `err` all 0; `out_digit` 000; ws/wc/iter 0.
- `rst` mid-operation: all state returns to reset values on the next edge. The partial result is discarded and `done` does not pulse.
- No-stall schedule, with start at cycle 0:
  - RUN and `in_ready` from cycle 1.
  - Digits accepted cycles 1..N.
  - Flush fires cycles N+1..N+2.
  - `out_valid` cycles 4..N+3.
  - `done` at cycle N+4.
  - `busy` falls at cycle N+5.
- Latency: first digit in to first digit out is DELTA+1 cycles.
- Backpressure: with `out_ready` low and `out_valid` high, no fire occurs.
  - `in_ready` is 0.
  - ws, wc, iter and `out_digit` hold.
- `done` and IDLE entry: `done` is registered, one cycle after the final handshake. The next start is accepted in the cycle after `done`.

## Structure
- Shared package `multiply_add_pkg` holds:
  - `digit_t` (logic [2:0]) and digit constants DIG_0/P1/P2/M1/M2;
  - a function `digit_legal`;
  - the enum `ma_state_t` {IDLE, RUN, FLUSH, DRAIN}.
- One sub-module: `multiply_add_stage`, instantiated once combinationally.
  - Driven by the latched `a` and the ws/wc registers, plus muxed x/c (zeroed in FLUSH or when illegal).
  - Its `j` input is the clamped index.
- The controller contains only registers, the FSM, the counter and the output register.

## Test plan
- All-zero: a=8'h40, X=C=all 000, out_ready=1 → eight `out_digit`=000; `out_last` on the 8th; `done` at cycle 12; `err`=0.
- Value: a=8'h40, x=001 then seven 000, C=0 → digit string equals 0.125 within 4^-8. Also check that random {a,X,C} vectors match a golden fraction model.
- Backpressure: out_ready low for 5 cycles mid-stream → `in_ready`=0 and `out_digit`/`out_valid` stable throughout; the final digit string is unchanged versus the no-stall run.
- Illegal digit: x=011 at digit 3 → `err`=1 from the next cycle and sticky through `done`; the result matches x=000 at that position; the next start clears `err`.
- Start while busy: start pulsed in RUN with a different `a` → ignored; the result uses the original `a`.
- Reset mid-op: `rst` at digit 5 → all outputs at reset values next cycle with no `done`; a fresh start then produces the correct all-zero result.
